inst_fetcher: RTL and testbench
===============================

# inst_fetcher

Consumer side of the PC register: reads the current `pc`, fetches the 32-bit instruction at that address over the byte-wide memory port, and presents it to the decode/issue stage with a valid/ready handshake. When the downstream stage accepts an instruction, the block pulses `pc_update` to advance the PC register, then fetches at the new `pc`. It sits in `if_unit` between `PcReg`, the memory arbiter and the instruction queue.

## Interface
- `ADDR_LEN`, 32, address width (from `defines.v`)
- `INST_LEN`, 32, instruction width (from `defines.v`)
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rdy`  in  1  global enable; low freezes the block
- `pc`  in  ADDR_LEN  current PC from PC register
- `pc_update`  out  1  one-cycle pulse; PC register advances on its rising edge
- `flush`  in  1  abort current fetch (branch/jump); PC already redirected externally
- `mem_req`  out  1  byte read request this cycle
- `mem_addr`  out  ADDR_LEN  byte address of request
- `mem_grant`  in  1  arbiter accepted this cycle's request
- `mem_din`  in  8  data for the request granted in the previous cycle
- `inst`  out  INST_LEN  assembled instruction
- `inst_pc`  out  ADDR_LEN  address of `inst`
- `inst_valid`  out  1  `inst` / `inst_pc` valid
- `inst_ready`  in  1  downstream accepts when high with `inst_valid`

## Operation
- States: SYNC, FETCH, DONE, ADVANCE.
- SYNC: latch `pc` into `fetch_pc`; clear issue count `icnt` and receive count `rcnt`; go to FETCH.
- FETCH: while `icnt < 4`, `mem_req=1`, `mem_addr = fetch_pc + icnt`. When `mem_grant` is high, `icnt` increments and a pending flag records the byte index. Requests are pipelined: a new request may issue in the same cycle the previous byte returns.
- Capture: the cycle after a granted request, `mem_din` is written to byte `rcnt` of the instruction buffer (little-endian: byte 0 goes to [7:0]), and `rcnt` increments. When `rcnt` reaches 4: `inst_valid=1`, `inst_pc=fetch_pc`, go to DONE.
- DONE: hold `inst`/`inst_pc`/`inst_valid` stable until `inst_valid && inst_ready`. On the accept edge, clear `inst_valid`, pulse `pc_update` for exactly one cycle, go to ADVANCE.
- ADVANCE: one cycle for the PC register to settle; go to SYNC.
- `mem_req=0` in SYNC, DONE and ADVANCE. `mem_addr` holds its last value when idle.
- Address arithmetic is modulo 2^ADDR_LEN; `fetch_pc + 3` wraps 0xFFFFFFFF to 0x00000000 without error.

## Timing
- Reset (async): state SYNC, `mem_req=0`, `mem_addr=0`, `inst=0`, `inst_pc=0`, `inst_valid=0`, `pc_update=0`, counters and pending flag cleared.
- Uncontended latency: SYNC at cycle S, requests at S+1..S+4, bytes return S+2..S+5, `inst_valid` high from S+6.
- Accept at cycle A: `pc_update` high during A+1 only; ADVANCE at A+1; SYNC at A+2 latches the new `pc`.
- `mem_grant` low: the same address is held and reissued the next cycle; `icnt` is unchanged.
- `flush` has highest priority (above `rdy` low and accept). On the next edge: `inst_valid=0`, counters and pending flag cleared, no `pc_update`, go to ADVANCE. A byte returning in the cycle after a flush is discarded.
- `flush` during DONE with `inst_ready` high: flush wins, and no `pc_update` is issued.
- `rdy` low: state, counters and outputs hold, `mem_req` is forced to 0, and `pc_update` is not asserted. A byte granted before `rdy` fell is still captured, because memory data is valid for only one cycle. A pending accept is deferred until `rdy` returns.
- `pc_update` never stays high for 2 consecutive cycles. There is at most one instruction in flight.

## Test plan
- Reset then fetch: `pc=0x1188`, grant always high, memory bytes 0x13,0x05,0x00,0x00 at 0x1188..0x118B -> `mem_addr` sequence 0x1188..0x118B, `inst=0x00000513`, `inst_pc=0x1188`, `inst_valid` asserted 6 cycles after reset release.
- Backpressure: hold `inst_ready=0` for 5 cycles -> `inst` stable, no `pc_update`. Raise `inst_ready` -> one-cycle `pc_update`, next fetch at `pc=0x118C`.
- Arbiter stall: `mem_grant` low on byte 2 for 3 cycles -> `mem_addr=0x118A` repeated, same `inst` value, `inst_valid` delayed by 3 cycles.
- Flush mid-fetch after 2 bytes, with `pc` changed to 0x2000 -> no `inst_valid` for the old fetch, no `pc_update`, next requests start at 0x2000.
- Freeze: `rdy` low for 4 cycles mid-fetch -> `mem_req=0`, counters held; fetch resumes and completes with the correct word.
- Wrap: `pc=0xFFFFFFFE` -> `mem_addr` sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; `inst_pc=0xFFFFFFFE`.

Source files
------------

// File: rtl/inst_fetcher.sv
// Instruction fetcher: assembles a 32-bit word from four byte reads at pc and
// hands it downstream with valid/ready, then pulses pc_update to advance the PC.
module inst_fetcher #(
    parameter int ADDR_LEN = 32,
    parameter int INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [ADDR_LEN-1:0] pc,
    output logic                pc_update,
    input  logic                flush,
    output logic                mem_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    input  logic                mem_grant,
    input  logic [7:0]          mem_din,
    output logic [INST_LEN-1:0] inst,
    output logic [ADDR_LEN-1:0] inst_pc,
    output logic                inst_valid,
    input  logic                inst_ready
);

    typedef enum logic [1:0] {SYNC, FETCH, DONE, ADVANCE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_LEN-1:0] fetch_pc;
    logic [ADDR_LEN-1:0] addr_q;
    logic [2:0]          icnt;
    logic [2:0]          rcnt;
    logic [2:0]          rcnt_nxt;
    logic                pending;
    logic                grant_fire;
    logic                capture;
    logic                fetch_done;
    logic                accept;

    assign grant_fire = mem_req && mem_grant;
    // Memory data lives for one cycle only, so capture ignores rdy.
    assign capture    = pending;
    assign rcnt_nxt   = rcnt + {2'b00, capture};
    assign fetch_done = (state == FETCH) && (rcnt_nxt == 3'd4);
    assign accept     = (state == DONE) && inst_valid && inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SYNC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ADVANCE;
        end else if (rdy) begin
            case (state)
                SYNC:    state_nxt = FETCH;
                FETCH:   if (fetch_done) state_nxt = DONE;
                DONE:    if (accept) state_nxt = ADVANCE;
                ADVANCE: state_nxt = SYNC;
                default: state_nxt = SYNC;
            endcase
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = addr_q;
        if (state == FETCH && icnt < 3'd4 && rdy && !flush) begin
            mem_req  = 1'b1;
            mem_addr = fetch_pc + ADDR_LEN'(icnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= '0;
            addr_q     <= '0;
            icnt       <= '0;
            rcnt       <= '0;
            pending    <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            pc_update  <= 1'b0;
        end else begin
            pc_update <= 1'b0;
            if (mem_req) addr_q <= mem_addr;
            if (capture) inst[{rcnt[1:0], 3'b000} +: 8] <= mem_din;
            if (flush) begin
                icnt       <= '0;
                rcnt       <= '0;
                pending    <= 1'b0;
                inst_valid <= 1'b0;
            end else begin
                pending <= grant_fire;
                if (capture) rcnt <= rcnt_nxt;
                if (grant_fire) icnt <= icnt + 3'd1;
                if (rdy) begin
                    case (state)
                        SYNC: begin
                            fetch_pc <= pc;
                            icnt     <= '0;
                            rcnt     <= '0;
                        end
                        FETCH: begin
                            if (fetch_done) begin
                                inst_valid <= 1'b1;
                                inst_pc    <= fetch_pc;
                            end
                        end
                        DONE: begin
                            if (accept) begin
                                inst_valid <= 1'b0;
                                pc_update  <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios with cycle-exact checks, then a
// randomized run checked against a transaction-level model of fetch/accept/PC.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        pc_update;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant = 1'b1;
    logic [7:0]  mem_din = 8'hA5;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] seed;
    logic [7:0]  mem_ovr [logic [31:0]];

    inst_fetcher dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pc(pc), .pc_update(pc_update),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_grant(mem_grant), .mem_din(mem_din), .inst(inst),
        .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        h = (a ^ seed) * 32'h9E3779B1;
        return h[31:24] ^ h[15:8];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Memory answers a granted request with its byte during the following cycle.
    task automatic adv();
        logic        fire;
        logic [31:0] faddr;
        fire  = mem_req && mem_grant;
        faddr = mem_addr;
        @(posedge clk);
        #1;
        mem_din = fire ? mem_byte(faddr) : 8'hA5;
    endtask

    // Leaves the bench just after an edge with rst low: the DUT is in its first cycle.
    task automatic do_reset(input logic [31:0] p);
        rst = 1'b1; flush = 1'b0; rdy = 1'b1; inst_ready = 1'b0; mem_grant = 1'b1; pc = p;
        at_neg();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_pc_update", pc_update, 0);
        adv();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] wexp [4];
        logic [31:0] mpc;
        logic [31:0] prev_inst;
        logic        prev_hold;
        logic        exp_upd;
        logic        acc;
        int          k;
        int          n_acc;

        seed = $urandom;
        mem_ovr[32'h1188] = 8'h13;
        mem_ovr[32'h1189] = 8'h05;
        mem_ovr[32'h118A] = 8'h00;
        mem_ovr[32'h118B] = 8'h00;

        // Uncontended fetch, backpressure, accept and next fetch
        do_reset(32'h1188);
        for (int c = 0; c <= 14; c++) begin
            inst_ready = (c == 11);
            at_neg();
            if (c >= 1 && c <= 4) begin
                chk("t1_req", mem_req, 1);
                chk("t1_addr", mem_addr, 32'h1188 + 32'(c) - 32'd1);
            end
            if (c == 0 || c == 5) chk("t1_idle", mem_req, 0);
            if (c == 5) chk("t1_early_valid", inst_valid, 0);
            if (c >= 6 && c <= 11) begin
                chk("t1_valid", inst_valid, 1);
                chk("t1_inst", inst, 32'h00000513);
                chk("t1_inst_pc", inst_pc, 32'h1188);
                chk("t2_no_update", pc_update, 0);
            end
            if (c == 12) begin
                chk("t2_update", pc_update, 1);
                chk("t2_valid_clr", inst_valid, 0);
                pc = 32'h118C;
            end
            if (c == 13) chk("t2_update_pulse", pc_update, 0);
            if (c == 14) begin
                chk("t2_next_req", mem_req, 1);
                chk("t2_next_addr", mem_addr, 32'h118C);
            end
            adv();
        end

        // Arbiter stall on byte 2
        do_reset(32'h1188);
        for (int c = 0; c <= 9; c++) begin
            mem_grant = !(c >= 3 && c <= 5);
            at_neg();
            if (c >= 3 && c <= 6) begin
                chk("t3_req", mem_req, 1);
                chk("t3_addr_hold", mem_addr, 32'h118A);
            end
            if (c == 7) chk("t3_addr3", mem_addr, 32'h118B);
            if (c == 8) chk("t3_early_valid", inst_valid, 0);
            if (c == 9) begin
                chk("t3_valid", inst_valid, 1);
                chk("t3_inst", inst, 32'h00000513);
            end
            adv();
        end
        mem_grant = 1'b1;

        // Flush after two bytes, redirect to 0x2000
        do_reset(32'h1188);
        for (int c = 0; c <= 11; c++) begin
            flush = (c == 3);
            if (c == 3) pc = 32'h2000;
            at_neg();
            if (c >= 4) chk("t4_no_update", pc_update, 0);
            if (c == 4 || c == 5) begin
                chk("t4_valid", inst_valid, 0);
                chk("t4_req", mem_req, 0);
            end
            if (c == 6) begin
                chk("t4_req_new", mem_req, 1);
                chk("t4_addr_new", mem_addr, 32'h2000);
            end
            if (c == 10) chk("t4_early_valid", inst_valid, 0);
            if (c == 11) begin
                chk("t4_valid_new", inst_valid, 1);
                chk("t4_inst", inst, word_at(32'h2000));
                chk("t4_inst_pc", inst_pc, 32'h2000);
            end
            adv();
        end
        flush = 1'b0;

        // rdy low for 4 cycles mid-fetch
        do_reset(32'h3000);
        for (int c = 0; c <= 10; c++) begin
            rdy = !(c >= 3 && c <= 6);
            at_neg();
            if (c >= 3 && c <= 6) chk("t5_req_frozen", mem_req, 0);
            if (c == 7) begin
                chk("t5_req_resume", mem_req, 1);
                chk("t5_addr_resume", mem_addr, 32'h3002);
            end
            if (c == 8) chk("t5_addr3", mem_addr, 32'h3003);
            if (c == 9) chk("t5_early_valid", inst_valid, 0);
            if (c == 10) begin
                chk("t5_valid", inst_valid, 1);
                chk("t5_inst", inst, word_at(32'h3000));
                chk("t5_inst_pc", inst_pc, 32'h3000);
            end
            adv();
        end
        rdy = 1'b1;

        // Address wrap, then an accept deferred by rdy low
        wexp = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        do_reset(32'hFFFFFFFE);
        for (int c = 0; c <= 10; c++) begin
            rdy = !(c == 6 || c == 7);
            inst_ready = (c >= 6 && c <= 8);
            at_neg();
            if (c >= 1 && c <= 4) chk("t6_wrap_addr", mem_addr, wexp[c-1]);
            if (c == 6) begin
                chk("t6_valid", inst_valid, 1);
                chk("t6_inst_pc", inst_pc, 32'hFFFFFFFE);
                chk("t6_inst", inst, word_at(32'hFFFFFFFE));
            end
            if (c >= 6 && c <= 8) begin
                chk("t6_deferred", pc_update, 0);
                chk("t6_valid_hold", inst_valid, 1);
            end
            if (c == 9) chk("t6_update", pc_update, 1);
            if (c == 10) chk("t6_update_pulse", pc_update, 0);
            adv();
        end
        inst_ready = 1'b0;
        rdy = 1'b1;

        // Flush beats accept in DONE
        do_reset(32'h4000);
        for (int c = 0; c <= 9; c++) begin
            inst_ready = (c == 6);
            flush = (c == 6);
            if (c == 6) pc = 32'h5000;
            at_neg();
            if (c == 6) chk("t7_valid", inst_valid, 1);
            if (c == 7) begin
                chk("t7_no_update", pc_update, 0);
                chk("t7_valid_clr", inst_valid, 0);
            end
            if (c == 8) begin
                chk("t7_no_update2", pc_update, 0);
                chk("t7_req_idle", mem_req, 0);
            end
            if (c == 9) begin
                chk("t7_req_new", mem_req, 1);
                chk("t7_addr_new", mem_addr, 32'h5000);
            end
            adv();
        end
        flush = 1'b0;
        inst_ready = 1'b0;

        // Randomized traffic against the transaction-level model
        mpc = $urandom;
        do_reset(mpc);
        k = 0; n_acc = 0; exp_upd = 1'b0; prev_hold = 1'b0; prev_inst = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mem_grant  = ($urandom_range(0, 9) < 7);
            rdy        = ($urandom_range(0, 9) < 8);
            inst_ready = $urandom_range(0, 1) == 1;
            flush      = ($urandom_range(0, 39) == 0);
            if (flush) begin
                mpc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
                pc  = mpc;
            end
            at_neg();
            acc = inst_valid && inst_ready && rdy && !flush;
            if (!rdy) chk("r_req_frozen", mem_req, 0);
            chk("r_pc_update", pc_update, exp_upd);
            if (mem_req && mem_grant) begin
                chk("r_req_bound", (k < 4), 1);
                chk("r_addr", mem_addr, mpc + 32'(k));
                k++;
            end
            if (prev_hold) begin
                chk("r_valid_hold", inst_valid, 1);
                chk("r_inst_hold", inst, prev_inst);
            end
            if (acc) begin
                chk("r_inst", inst, word_at(mpc));
                chk("r_inst_pc", inst_pc, mpc);
                chk("r_bytes", k, 4);
                n_acc++;
            end
            prev_hold = inst_valid && !acc && !flush;
            prev_inst = inst;
            if (exp_upd && !flush) begin
                mpc = mpc + 32'd4;
                pc  = mpc;
                k   = 0;
            end
            if (flush) k = 0;
            exp_upd = acc;
            adv();
        end
        chk("r_accept_count", (n_acc > 10), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
